// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared FSM state type and default pattern for the serial pattern path
//
// Imported by the serializer and by the bit-serial detectors, so both sides
// agree on the reference pattern and its length.

package seq_pkg;

    // Serializer control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_e;

    // Reference pattern, transmitted MSB first.
    localparam int                     SEQ_PAT_LEN = 6;
    localparam logic [SEQ_PAT_LEN-1:0] SEQ_PATTERN = 6'b110011;

endpackage

// File: rtl/pattern_bit_counter.sv
// rtl/pattern_bit_counter.sv - loadable down-counter with zero flag
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   load       load load_val (takes priority over dec)
//   load_val   value to load
//   dec        decrement by one; holds at zero rather than wrapping
//   count      current count
//   zero       high when count is zero

module pattern_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/pattern_serializer.sv
// rtl/pattern_serializer.sv - repeating fixed-pattern serial transmitter with gap and handshake
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   start        launch request, sampled only in IDLE
//   repeat_cnt   frames to send, latched on accepted start (0 = finish at once)
//   gap_len      idle cycles between frames, latched on accepted start
//   abort        synchronous stop; drops the burst without a done pulse
//   out_bit      registered serial data
//   out_valid    out_bit carries a pattern bit
//   frame_last   final bit of each frame
//   busy         burst in progress
//   done         one-cycle completion pulse
//
// All outputs are registered from the current state, so they lag the state
// register by one cycle: a start accepted at edge N shows its first bit and
// busy after edge N+1. Abort is folded into the output register directly so
// the line goes quiet on the same edge the FSM returns to IDLE.

module pattern_serializer
    import seq_pkg::*;
#(
    parameter int                 PAT_LEN    = SEQ_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN    = SEQ_PATTERN,
    parameter int                 CNT_W      = 8,
    parameter int                 GAP_W      = 4,
    parameter logic               IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             out_bit,
    output logic             out_valid,
    output logic             frame_last,
    output logic             busy,
    output logic             done
);

    // The bit-index counter doubles as the gap counter, so it must hold
    // whichever range is larger.
    localparam int IDX_W = $clog2(PAT_LEN);
    localparam int CW    = (IDX_W > GAP_W) ? IDX_W : GAP_W;
    localparam logic [CW-1:0] IDX_TOP = CW'(PAT_LEN - 1);

    seq_state_e state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic          bit_load, bit_dec, bit_zero;
    logic [CW-1:0] bit_load_val, bit_cnt;

    logic             frm_load, frm_dec, frm_zero;
    logic [CNT_W-1:0] frm_load_val;
    logic [CNT_W-1:0] frm_cnt_unused;

    logic out_bit_q, out_valid_q, frame_last_q, busy_q, done_q;
    logic out_bit_d, out_valid_d, frame_last_d, busy_d, done_d;

    logic [PAT_LEN-1:0] pat_shifted;

    pattern_bit_counter #(.W(CW)) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (bit_load),
        .load_val (bit_load_val),
        .dec      (bit_dec),
        .count    (bit_cnt),
        .zero     (bit_zero)
    );

    // Holds frames remaining after the current one, so zero at the last
    // bit means the burst is complete.
    pattern_bit_counter #(.W(CNT_W)) u_frm_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (frm_load),
        .load_val (frm_load_val),
        .dec      (frm_dec),
        .count    (frm_cnt_unused),
        .zero     (frm_zero)
    );

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        bit_load     = 1'b0;
        bit_load_val = '0;
        bit_dec      = 1'b0;
        frm_load     = 1'b0;
        frm_load_val = '0;
        frm_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Abort outranks a simultaneous start.
                if (start && !abort) begin
                    if (repeat_cnt != '0) begin
                        state_d      = ST_SEND;
                        gap_d        = gap_len;
                        bit_load     = 1'b1;
                        bit_load_val = IDX_TOP;
                        frm_load     = 1'b1;
                        frm_load_val = repeat_cnt - 1'b1;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_zero) begin
                    if (frm_zero) begin
                        state_d = ST_FIN;
                    end else begin
                        frm_dec  = 1'b1;
                        bit_load = 1'b1;
                        if (gap_q != '0) begin
                            // Counter ends at zero, so load one less than
                            // the number of gap cycles.
                            state_d      = ST_GAP;
                            bit_load_val = CW'(gap_q - 1'b1);
                        end else begin
                            bit_load_val = IDX_TOP;
                        end
                    end
                end else begin
                    bit_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_zero) begin
                    state_d      = ST_SEND;
                    bit_load     = 1'b1;
                    bit_load_val = IDX_TOP;
                end else begin
                    bit_dec = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pat_shifted = PATTERN >> bit_cnt;

    always_comb begin
        out_bit_d    = IDLE_LEVEL;
        out_valid_d  = 1'b0;
        frame_last_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_SEND: begin
                if (!abort) begin
                    out_bit_d    = pat_shifted[0];
                    out_valid_d  = 1'b1;
                    frame_last_d = bit_zero;
                    busy_d       = 1'b1;
                end
            end
            ST_GAP: begin
                busy_d = !abort;
            end
            ST_FIN: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gap_q        <= '0;
            out_bit_q    <= IDLE_LEVEL;
            out_valid_q  <= 1'b0;
            frame_last_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            out_bit_q    <= out_bit_d;
            out_valid_q  <= out_valid_d;
            frame_last_q <= frame_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign out_bit    = out_bit_q;
    assign out_valid  = out_valid_q;
    assign frame_last = frame_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// tb/tb_pattern_serializer.sv - self-checking bench for pattern_serializer

module tb_pattern_serializer;

    localparam int PAT_LEN = 6;
    localparam int CNT_W   = 8;
    localparam int GAP_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             abort;
    logic             out_bit, out_valid, frame_last, busy, done;

    logic [4:0] obs;
    assign obs = {out_bit, out_valid, frame_last, busy, done};

    // Expected per-cycle {out_bit, out_valid, frame_last, busy, done},
    // starting with the cycle after the accepting edge.
    logic [4:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .abort      (abort),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .frame_last (frame_last),
        .busy       (busy),
        .done       (done)
    );

    // Burst as a flat list: rc frames of the pattern, gl idle cycles between
    // frames, a done cycle, then one quiet cycle.
    function automatic void build_expected(int rc, int gl);
        logic [5:0] pat;
        logic       b;
        pat = 6'b110011;
        exp_q.delete();
        for (int f = 0; f < rc; f++) begin
            for (int k = 0; k < PAT_LEN; k++) begin
                b = pat[PAT_LEN-1-k];
                exp_q.push_back({b, 1'b1, (k == PAT_LEN-1), 1'b1, 1'b0});
            end
            if (f < rc - 1) begin
                for (int g = 0; g < gl; g++) exp_q.push_back(5'b00010);
            end
        end
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00000);
    endfunction

    // Called at a negedge; returns just after the accepting edge.
    task automatic launch(int rc, int gl);
        repeat_cnt = CNT_W'(rc);
        gap_len    = GAP_W'(gl);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        repeat_cnt = CNT_W'($urandom);
        gap_len    = GAP_W'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; repeat_cnt = '0; gap_len = '0;
        #12;
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL idle_after_reset[%0d]: got %b want 00000", i, obs);
            end
        end
    endtask

    task automatic test_single();
        build_expected(1, 0);
        launch(1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL single_frame[%0d]: got %b want %b", i, obs, exp_q[i]);
            end
        end
    endtask

    // Random bursts plus the extremes; a start pulse mid-burst must be ignored.
    task automatic test_bursts();
        int rc, gl;
        for (int n = 0; n < 12; n++) begin
            rc = $urandom_range(1, 4);
            gl = $urandom_range(0, 3);
            if (n == 0) begin rc = 3;   gl = 0;  end
            if (n == 1) begin rc = 2;   gl = 2;  end
            if (n == 2) begin rc = 2;   gl = 15; end
            if (n == 3) begin rc = 255; gl = 0;  end
            build_expected(rc, gl);
            launch(rc, gl);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(posedge clk); @(negedge clk);
                checks++;
                if (obs !== exp_q[i]) begin
                    errors++;
                    $display("FAIL burst%0d rc=%0d gl=%0d [%0d]: got %b want %b",
                             n, rc, gl, i, obs, exp_q[i]);
                end
                if (i == 2) begin
                    start      = 1'b1;
                    repeat_cnt = 8'd5;
                end else begin
                    start = 1'b0;
                end
            end
            start = 1'b0;
        end
    endtask

    task automatic test_zero_repeat();
        build_expected(0, $urandom_range(0, 15));
        launch(0, 3);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL zero_repeat[%0d]: got %b want %b", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_abort();
        int ai;
        // Abort on the 3rd bit of frame 2.
        build_expected(3, 1);
        ai = PAT_LEN + 1 + 2;
        launch(3, 1);
        for (int i = 0; i <= ai; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL pre_abort[%0d]: got %b want %b", i, obs, exp_q[i]);
            end
        end
        abort = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0;
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL after_abort: got %b want 00000", obs);
        end
        // Restart immediately; the new burst must be whole and clean.
        build_expected(1, 0);
        launch(1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL restart_after_abort[%0d]: got %b want %b", i, obs, exp_q[i]);
            end
        end
        // abort together with start in IDLE launches nothing.
        abort = 1'b1;
        launch(2, 0);
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL abort_beats_start[%0d]: got %b want 00000", i, obs);
            end
        end
    endtask

    task automatic test_async_reset();
        build_expected(2, 3);
        launch(2, 3);
        // Run into the first gap cycle.
        for (int i = 0; i <= PAT_LEN; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL pre_reset[%0d]: got %b want %b", i, obs, exp_q[i]);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL async_reset_mid_gap: got %b want 00000", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL idle_after_async_reset[%0d]: got %b want 00000", i, obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bursts();
        test_zero_repeat();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
